// File: rtl/jtexterm_pkg.sv
// Shared types and xRGB555 field positions for the Extermination palette path.
package jtexterm_pkg;

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} fetch_st_e;

   // Bit positions inside the two bytes of one xRGB555 palette entry
   localparam int R_MSB    = 6;
   localparam int R_LSB    = 2;
   localparam int G_HI_MSB = 1;
   localparam int G_HI_LSB = 0;
   localparam int G_LO_MSB = 7;
   localparam int G_LO_LSB = 5;
   localparam int B_MSB    = 4;
   localparam int B_LSB    = 0;

endpackage

// File: rtl/jtexterm_rgb555_unpack.sv
// Splits the high/low bytes of an xRGB555 palette entry into 5-bit R/G/B.
module jtexterm_rgb555_unpack
   import jtexterm_pkg::*;
(
   input  logic [7:0] hi_i,
   input  logic [7:0] lo_i,
   output logic [4:0] r_o,
   output logic [4:0] g_o,
   output logic [4:0] b_o
);

   // Bit 7 of the high byte carries no colour information
   logic unused_hi7;
   assign unused_hi7 = hi_i[7];

   assign r_o = hi_i[R_MSB:R_LSB];
   assign g_o = {hi_i[G_HI_MSB:G_HI_LSB], lo_i[G_LO_MSB:G_LO_LSB]};
   assign b_o = lo_i[B_MSB:B_LSB];

endmodule

// File: rtl/jtexterm_palfetch.sv
// Palette fetch sequencer: two byte reads per pixel from the palette RAM,
// RGB assembly and one-pixel-delayed, blank-gated video output.
module jtexterm_palfetch
   import jtexterm_pkg::*;
#(
   parameter int AW     = 10,
   parameter int RD_LAT = 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pxl_cen,
   input  logic          LHBL,
   input  logic          LVBL,
   input  logic [AW-2:0] pxl,
   output logic [AW-1:0] pal_addr,
   input  logic [7:0]    pal_dout,
   output logic [4:0]    red,
   output logic [4:0]    green,
   output logic [4:0]    blue,
   output logic          LHBL_dly,
   output logic          LVBL_dly,
   output logic          overrun
);

   localparam logic [1:0] LAT_RELOAD = 2'(RD_LAT);

   fetch_st_e     state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-2:0] idx_q;
   logic          blank_q, lhbl_q, lvbl_q;
   logic [7:0]    lo_q, hi_q, hi_src;
   logic [14:0]   rgb_q;
   logic [4:0]    r_w, g_w, b_w;
   logic [4:0]    red_q, green_q, blue_q;
   logic          lhbl_dly_q, lvbl_dly_q, overrun_q;
   logic          lo_cap, hi_cap;

   // The high byte is assembled straight from the RAM so the colour is
   // ready one clk after the last read, meeting the minimum pxl_cen period.
   assign hi_src = hi_cap ? pal_dout : hi_q;

   jtexterm_rgb555_unpack u_unpack (
      .hi_i (hi_src),
      .lo_i (lo_q),
      .r_o  (r_w),
      .g_o  (g_w),
      .b_o  (b_w)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      lo_cap  = 1'b0;
      hi_cap  = 1'b0;
      if (pxl_cen) begin
         state_d = LO;
         addr_d  = {pxl, 1'b0};
         cnt_d   = LAT_RELOAD;
      end else begin
         case (state_q)
            LO: begin
               if (cnt_q == 2'd0) begin
                  lo_cap  = 1'b1;
                  state_d = HI;
                  addr_d  = {idx_q, 1'b1};
                  cnt_d   = LAT_RELOAD;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            HI: begin
               if (cnt_q == 2'd0) begin
                  hi_cap  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         idx_q      <= '0;
         blank_q    <= 1'b0;
         lhbl_q     <= 1'b0;
         lvbl_q     <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
         rgb_q      <= '0;
         red_q      <= '0;
         green_q    <= '0;
         blue_q     <= '0;
         lhbl_dly_q <= 1'b0;
         lvbl_dly_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         if (lo_cap) lo_q <= pal_dout;
         if (hi_cap) begin
            hi_q  <= pal_dout;
            rgb_q <= {r_w, g_w, b_w};
         end
         // rgb_q only moves on a completed fetch, so an overrun repeats it
         if (pxl_cen) begin
            idx_q   <= pxl;
            blank_q <= ~(LHBL & LVBL);
            lhbl_q  <= LHBL;
            lvbl_q  <= LVBL;
            {red_q, green_q, blue_q} <= blank_q ? 15'd0 : rgb_q;
            lhbl_dly_q <= lhbl_q;
            lvbl_dly_q <= lvbl_q;
            if (state_q == LO || state_q == HI) overrun_q <= 1'b1;
         end
      end
   end

   assign pal_addr = addr_q;
   assign red      = red_q;
   assign green    = green_q;
   assign blue     = blue_q;
   assign LHBL_dly = lhbl_dly_q;
   assign LVBL_dly = lvbl_dly_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_jtexterm_palfetch.sv
// Scoreboard bench: directed RD_LAT=1 instance plus a random RD_LAT=2 instance.
module tb_jtexterm_palfetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [14:0] C5 = {5'h1F, 5'b10101, 5'h03};
   localparam logic [14:0] CW = {5'd0, 5'd0, 5'd31};

   // ---------------- instance A: RD_LAT=1 ----------------
   logic       rst_a = 1'b1, cen_a = 1'b0, lh_a = 1'b0, lv_a = 1'b0;
   logic [8:0] pxl_a = '0;
   logic [9:0] addr_a;
   logic [7:0] q_a = '0;
   logic [4:0] r_a, g_a, b_a;
   logic       lhd_a, lvd_a, ov_a;
   logic [7:0] mem_a [1024];

   jtexterm_palfetch #(.AW(10), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_a), .pxl_cen(cen_a), .LHBL(lh_a), .LVBL(lv_a),
      .pxl(pxl_a), .pal_addr(addr_a), .pal_dout(q_a),
      .red(r_a), .green(g_a), .blue(b_a),
      .LHBL_dly(lhd_a), .LVBL_dly(lvd_a), .overrun(ov_a)
   );
   always @(posedge clk) q_a <= mem_a[addr_a];

   // ---------------- instance B: RD_LAT=2 ----------------
   logic       rst_b = 1'b1, cen_b = 1'b0, lh_b = 1'b0, lv_b = 1'b0;
   logic [8:0] pxl_b = '0;
   logic [9:0] addr_b;
   logic [7:0] q_b1 = '0, q_b = '0;
   logic [4:0] r_b, g_b, b_b;
   logic       lhd_b, lvd_b, ov_b;
   logic [7:0] mem_b [1024];

   jtexterm_palfetch #(.AW(10), .RD_LAT(2)) dut_b (
      .clk(clk), .rst_n(rst_b), .pxl_cen(cen_b), .LHBL(lh_b), .LVBL(lv_b),
      .pxl(pxl_b), .pal_addr(addr_b), .pal_dout(q_b),
      .red(r_b), .green(g_b), .blue(b_b),
      .LHBL_dly(lhd_b), .LVBL_dly(lvd_b), .overrun(ov_b)
   );
   always @(posedge clk) begin
      q_b1 <= mem_b[addr_b];
      q_b  <= q_b1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [17:0] E(input logic [14:0] c, input logic lh, input logic lv,
                                     input logic ov);
      return {c, lh, lv, ov};
   endfunction

   function automatic logic [14:0] ref_rgb(input logic [7:0] hi, input logic [7:0] lo);
      return {hi[6:2], hi[1:0], lo[7:5], lo[4:0]};
   endfunction

   // ---------------- scoreboards / monitors ----------------
   logic [17:0] exp_a[$];
   logic [17:0] exp_b[$];
   logic cena_d = 1'b0, cenb_d = 1'b0;
   int na = 0, nb = 0;

   always @(posedge clk) begin
      cena_d <= cen_a;
      cenb_d <= cen_b;
   end

   always @(negedge clk) begin
      if (cena_d) begin
         if (exp_a.size() == 0) check("A_unexpected_output", 32'd1, 32'd0);
         else begin
            logic [17:0] e;
            e = exp_a.pop_front();
            check($sformatf("A_pix%0d", na), {14'd0, r_a, g_a, b_a, lhd_a, lvd_a, ov_a}, {14'd0, e});
            na++;
         end
      end
      if (cenb_d) begin
         if (exp_b.size() == 0) check("B_unexpected_output", 32'd1, 32'd0);
         else begin
            logic [17:0] e;
            e = exp_b.pop_front();
            check($sformatf("B_pix%0d", nb), {14'd0, r_b, g_b, b_b, lhd_b, lvd_b, ov_b}, {14'd0, e});
            nb++;
         end
      end
   end

   // Issue one pixel on A; optionally check the LO then HI address; next cen lands gap clk later.
   task automatic pix_a(input logic [8:0] p, input logic lh, input logic lv, input logic [17:0] e,
                        input int gap, input bit chk, input logic [9:0] a0);
      pxl_a = p; lh_a = lh; lv_a = lv; cen_a = 1'b1;
      exp_a.push_back(e);
      @(posedge clk); #1 cen_a = 1'b0;
      if (chk) begin
         check("A_addr_lo", {22'd0, addr_a}, {22'd0, a0});
         @(posedge clk); @(posedge clk); #1;
         check("A_addr_hi", {22'd0, addr_a}, {22'd0, a0 + 10'd1});
         repeat (gap - 3) @(posedge clk);
      end else begin
         repeat (gap - 1) @(posedge clk);
      end
      #1;
   endtask

   task automatic pix_b(input logic [8:0] p, input logic lh, input logic lv, input logic [17:0] e);
      pxl_b = p; lh_b = lh; lv_b = lv; cen_b = 1'b1;
      exp_b.push_back(e);
      @(posedge clk); #1 cen_b = 1'b0;
      repeat (7) @(posedge clk);
      #1;
   endtask

   task automatic run_a();
      // normal colour, blanking on each blank input, index wrap
      pix_a(9'd5,   1, 1, E(15'd0, 0, 0, 0), 8, 1, 10'd10);
      pix_a(9'd5,   0, 1, E(C5,    1, 1, 0), 8, 0, 10'd0);
      pix_a(9'd5,   1, 1, E(15'd0, 0, 1, 0), 8, 0, 10'd0);
      pix_a(9'h1FF, 1, 1, E(C5,    1, 1, 0), 8, 1, 10'h3FE);
      pix_a(9'd5,   1, 0, E(CW,    1, 1, 0), 8, 0, 10'd0);
      pix_a(9'd5,   1, 1, E(15'd0, 1, 0, 0), 8, 0, 10'd0);
      pix_a(9'd5,   1, 1, E(C5,    1, 1, 0), 8, 0, 10'd0);
      // pxl_cen too fast: sticky overrun, last completed colour repeated
      pix_a(9'h1FF, 1, 1, E(C5,    1, 1, 0), 3, 0, 10'd0);
      pix_a(9'h1FF, 1, 1, E(C5,    1, 1, 1), 3, 0, 10'd0);
      pix_a(9'h1FF, 1, 1, E(C5,    1, 1, 1), 3, 0, 10'd0);
      pix_a(9'h1FF, 1, 1, E(C5,    1, 1, 1), 8, 0, 10'd0);
      pix_a(9'd5,   1, 1, E(CW,    1, 1, 1), 8, 0, 10'd0);
      // asynchronous reset while the HI read is outstanding
      pix_a(9'd5,   1, 1, E(C5,    1, 1, 1), 3, 1, 10'd10);
      rst_a = 1'b0;
      #2;
      check("A_async_rst_out", {14'd0, r_a, g_a, b_a, lhd_a, lvd_a, ov_a}, 32'd0);
      check("A_async_rst_addr", {22'd0, addr_a}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b1;
      @(posedge clk); #1;
      pix_a(9'd5, 1, 1, E(15'd0, 0, 0, 0), 8, 0, 10'd0);
      pix_a(9'd5, 1, 1, E(C5,    1, 1, 0), 8, 0, 10'd0);
   endtask

   task automatic run_b();
      logic [8:0] p, pp;
      logic lh, lv, plh, plv, pblank, have;
      pp = '0; plh = 1'b0; plv = 1'b0; pblank = 1'b0; have = 1'b0;
      for (int i = 0; i <= 256; i++) begin
         logic [14:0] c;
         p  = 9'($urandom_range(0, 511));
         lh = ($urandom_range(0, 7) != 0);
         lv = ($urandom_range(0, 7) != 0);
         c  = (!have || pblank) ? 15'd0 : ref_rgb(mem_b[{pp, 1'b1}], mem_b[{pp, 1'b0}]);
         pix_b(p, lh, lv, E(c, plh, plv, 1'b0));
         pp = p; plh = lh; plv = lv; pblank = ~(lh & lv); have = 1'b1;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'($urandom);
      end
      mem_a[10]     = 8'hA3;
      mem_a[11]     = 8'h7E;
      mem_a[10'h3FE] = 8'h1F;
      mem_a[10'h3FF] = 8'h80;
      #1 rst_a = 1'b0; rst_b = 1'b0;
      #2;
      check("A_reset_out", {14'd0, r_a, g_a, b_a, lhd_a, lvd_a, ov_a}, 32'd0);
      check("A_reset_addr", {22'd0, addr_a}, 32'd0);
      check("B_reset_out", {14'd0, r_b, g_b, b_b, lhd_b, lvd_b, ov_b}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b1; rst_b = 1'b1;
      @(posedge clk); #1;
      fork
         run_a();
         run_b();
      join
      repeat (4) @(posedge clk);
      #1;
      check("A_queue_drained", exp_a.size(), 32'd0);
      check("B_queue_drained", exp_b.size(), 32'd0);
      check("B_no_overrun", {31'd0, ov_b}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
